// File: rtl/aud_mix_multi.sv
// Time-multiplexed NCH-source stereo mixer: one shared accumulator per side,
// then crossfeed, master attenuation, clamp and dither. Optional clip flags: AUD_MIX_CLIP_DETECT_EN.
module aud_mix_multi #(
    parameter int DW  = 16,
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [NCH*DW-1:0] in_l,
    input  logic [NCH*DW-1:0] in_r,
    input  logic [NCH*4-1:0]  ch_att,
    input  logic [NCH-1:0]    ch_mute,
    input  logic [1:0]        mix,
    input  logic [4:0]        att,
    output logic [DW-1:0]     out_l,
    output logic [DW-1:0]     out_r,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              clip_l,
    output logic              clip_r
);
    localparam int AW = DW + $clog2(NCH) + 2;
    localparam int KW = $clog2(NCH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SNAP  = 3'd1;
    localparam logic [2:0] ACC   = 3'd2;
    localparam logic [2:0] XMIX  = 3'd3;
    localparam logic [2:0] SCALE = 3'd4;
    localparam logic [2:0] OUT   = 3'd5;

    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [2:0]         state_reg;
    logic [KW-1:0]      k_reg;
    logic signed [AW-1:0] acc_l_reg, acc_r_reg;
    logic [DW-1:0]      prev_l_reg, prev_r_reg;

    logic [NCH*DW-1:0]  in_l_reg, in_r_reg;
    logic [NCH*4-1:0]   ch_att_reg;
    logic [NCH-1:0]     ch_mute_reg;
    logic [1:0]         mix_reg;
    logic [4:0]         att_reg;

    logic [DW-1:0] src_l [NCH];
    logic [DW-1:0] src_r [NCH];
    logic [3:0]    src_att [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_src
            assign src_l[gi]   = in_l_reg[gi*DW +: DW];
            assign src_r[gi]   = in_r_reg[gi*DW +: DW];
            assign src_att[gi] = ch_att_reg[gi*4 +: 4];
        end
    endgenerate

    assign busy = (state_reg != IDLE);

    // Current source term: sign-extend, arithmetic shift, zero when muted
    logic signed [AW-1:0] ext_l, ext_r, term_l, term_r;
    assign ext_l  = signed'({{(AW-DW){src_l[k_reg][DW-1]}}, src_l[k_reg]});
    assign ext_r  = signed'({{(AW-DW){src_r[k_reg][DW-1]}}, src_r[k_reg]});
    assign term_l = ch_mute_reg[k_reg] ? '0 : (ext_l >>> src_att[k_reg]);
    assign term_r = ch_mute_reg[k_reg] ? '0 : (ext_r >>> src_att[k_reg]);

    logic signed [AW-1:0] x_l, x_r;
    always_comb begin
        x_l = acc_l_reg;
        x_r = acc_r_reg;
        case (mix_reg)
            2'd1: begin
                x_l = acc_l_reg - (acc_l_reg >>> 3) + (acc_r_reg >>> 2);
                x_r = acc_r_reg - (acc_r_reg >>> 3) + (acc_l_reg >>> 2);
            end
            2'd2: begin
                x_l = acc_l_reg - (acc_l_reg >>> 2) + (acc_r_reg >>> 1);
                x_r = acc_r_reg - (acc_r_reg >>> 2) + (acc_l_reg >>> 1);
            end
            2'd3: begin
                x_l = (acc_l_reg >>> 1) + (acc_r_reg >>> 1);
                x_r = x_l;
            end
            default: ;
        endcase
    end

    logic signed [AW-1:0] sc_l, sc_r;
    assign sc_l = att_reg[4] ? '0 : (acc_l_reg >>> att_reg[3:0]);
    assign sc_r = att_reg[4] ? '0 : (acc_r_reg >>> att_reg[3:0]);

    logic sat_hi_l, sat_lo_l, sat_hi_r, sat_lo_r;
    logic [DW-1:0] cl_l, cl_r, nxt_l, nxt_r;
    assign sat_hi_l = (sc_l > MAXV);
    assign sat_lo_l = (sc_l < MINV);
    assign sat_hi_r = (sc_r > MAXV);
    assign sat_lo_r = (sc_r < MINV);
    assign cl_l = sat_hi_l ? MAXV[DW-1:0] : (sat_lo_l ? MINV[DW-1:0] : sc_l[DW-1:0]);
    assign cl_r = sat_hi_r ? MAXV[DW-1:0] : (sat_lo_r ? MINV[DW-1:0] : sc_r[DW-1:0]);

    // Anti-idle toggle: keep a silent output moving so downstream sinks never see DC idle
    assign nxt_l = (cl_l == '0 && prev_l_reg == '0 && (out_l == '0 || out_l == '1)) ? ~out_l : cl_l;
    assign nxt_r = (cl_r == '0 && prev_r_reg == '0 && (out_r == '0 || out_r == '1)) ? ~out_r : cl_r;

    always_ff @(posedge clk) begin
        if (state_reg == SNAP) begin
            in_l_reg    <= in_l;
            in_r_reg    <= in_r;
            ch_att_reg  <= ch_att;
            ch_mute_reg <= ch_mute;
            mix_reg     <= mix;
            att_reg     <= att;
        end
    end

    // Output stage is written on the edge that enters OUT so out_valid is high during OUT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            k_reg      <= '0;
            acc_l_reg  <= '0;
            acc_r_reg  <= '0;
            prev_l_reg <= '0;
            prev_r_reg <= '0;
            out_l      <= '0;
            out_r      <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (ce && state_reg != IDLE)
                overrun <= 1'b1;
            case (state_reg)
                IDLE: if (ce) state_reg <= SNAP;
                SNAP: begin
                    acc_l_reg <= '0;
                    acc_r_reg <= '0;
                    k_reg     <= '0;
                    state_reg <= ACC;
                end
                ACC: begin
                    acc_l_reg <= acc_l_reg + term_l;
                    acc_r_reg <= acc_r_reg + term_r;
                    if (k_reg == KW'(NCH-1))
                        state_reg <= XMIX;
                    else
                        k_reg <= k_reg + 1'b1;
                end
                XMIX: begin
                    acc_l_reg <= x_l;
                    acc_r_reg <= x_r;
                    state_reg <= SCALE;
                end
                SCALE: begin
                    out_l      <= nxt_l;
                    out_r      <= nxt_r;
                    prev_l_reg <= cl_l;
                    prev_r_reg <= cl_r;
                    out_valid  <= 1'b1;
                    state_reg  <= OUT;
                end
                OUT:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef AUD_MIX_CLIP_DETECT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_l <= 1'b0;
            clip_r <= 1'b0;
        end else if (state_reg == SNAP) begin
            clip_l <= 1'b0;
            clip_r <= 1'b0;
        end else if (state_reg == SCALE) begin
            clip_l <= sat_hi_l | sat_lo_l;
            clip_r <= sat_hi_r | sat_lo_r;
        end
    end
`else
    assign clip_l = 1'b0;
    assign clip_r = 1'b0;
`endif
endmodule

// File: doc/aud_mix_multi.md
Name: aud_mix_multi

Overview:
- Parametrised, time-multiplexed N-source stereo mixer. Successor to the per-side two-input mixer.
- Per pass, sums NCH stereo sources sequentially through one shared accumulator per side. Each source has its own attenuation and mute.
- After summing: crossfeed mode, master attenuation, saturation and anti-idle dither toggle.
- Sits between the DC blockers / Linux audio sources and the I2S/SPDIF/sigma-delta outputs in the audio output path.

Parameters:
- DW, 16, sample width (signed two's complement, in and out).
- NCH, 4, number of stereo sources (2..16).
- AW, DW+$clog2(NCH)+2, internal accumulator width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  sample strobe; starts one mix pass.
- in_l  in  NCH*DW  left samples; source k at [k*DW +: DW].
- in_r  in  NCH*DW  right samples, same packing.
- ch_att  in  NCH*4  per-source right-shift attenuation; source k at [k*4 +: 4].
- ch_mute  in  NCH  per-source mute.
- mix  in  2  crossfeed mode.
- att  in  5  master attenuation; bit 4 = full mute.
- out_l  out  DW  mixed left sample.
- out_r  out  DW  mixed right sample.
- out_valid  out  1  one-cycle pulse when out_l/out_r update.
- busy  out  1  pass in progress.
- overrun  out  1  sticky: a ce was dropped.
- clip_l, clip_r  out  1  clip flags (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0): out_l/out_r=0, out_valid=0, busy=0, overrun=0, clip flags=0, accumulators=0, previous-clamped registers=0, state IDLE.
- States:
  - IDLE -> SNAP on ce.
  - SNAP: captures all inputs (in_*, ch_att, ch_mute, mix, att) into shadow regs; clears accumulators; k=0; -> ACC.
  - ACC: one source per cycle; k increments; after k=NCH-1 -> XMIX.
  - XMIX -> SCALE -> OUT -> IDLE.
- Input changes after the SNAP edge do not affect the pass.
- Latency: ce sampled at edge T0; out_* and out_valid update at edge T0+NCH+3; out_valid high exactly one cycle.
- busy = (state != IDLE).
- A ce seen while busy, including during OUT, is dropped and sets overrun; overrun clears only on reset.
- ACC term: sample sign-extended to AW, then >>> ch_att[k] (arithmetic). Term is 0 if ch_mute[k]. Accumulation is in AW bits; no overflow is possible.
- XMIX, with S_L/S_R the sums, simultaneous for both sides:
  - mix 0: L'=S_L, R'=S_R.
  - mix 1: L'=S_L-(S_L>>>3)+(S_R>>>2); R' symmetric.
  - mix 2: L'=S_L-(S_L>>>2)+(S_R>>>1); R' symmetric.
  - mix 3: L'=(S_L>>>1)+(S_R>>>1); R'=L'.
- SCALE: value is 0 if att[4], else value >>> att[3:0].
- OUT:
  - Clamp to signed DW: >max gives 0x7FFF, <min gives 0x8000 (for DW=16).
  - Dither toggle, per side: if the clamped value is 0, the previous pass's clamped value is 0, and the current out is all-zeros or all-ones, then out <= ~out. Otherwise out <= clamped.
  - The previous-clamped register updates only in OUT.
- Reset mid-pass: pass abandoned; no out_valid; state IDLE.

Optional Feature:
- Macro: AUD_MIX_CLIP_DETECT_EN.
- Defined: clip_l/clip_r set in OUT when that side's clamp saturates; cleared at the start of each pass (SNAP), i.e. they reflect the most recent pass; reset 0.
- Undefined: clip_l/clip_r tied 0; no clip logic synthesised; all other behaviour identical.

Test Plan (DW=16, NCH=4):
- Reset asserted mid-pass -> out_l=out_r=0, busy=0, overrun=0, no out_valid afterward until next ce.
- ce with src0 L=0x1000, others 0, ch_att=0, mix=0, att=0 -> out_valid exactly 7 cycles after ce edge, one cycle wide; out_l=0x1000, out_r=0x0000 toggles to 0xFFFF (dither, prev=0).
- All four sources L=0x7000, R=0x9000, mix=0 -> out_l=0x7FFF, out_r=0x8000; with AUD_MIX_CLIP_DETECT_EN, clip_l=clip_r=1.
- mix=3, src0 L=0x2000, R=0, others muted via ch_mute=4'b1110 with nonzero data -> out_l=out_r=0x1000. Then ch_att src0=2 -> out_l=0x0400.
- Second ce issued 3 cycles after first -> dropped, busy stays 1, overrun=1 and persists; only one out_valid.
- Three consecutive passes with all inputs 0 -> out_l: 0xFFFF, 0x0000, 0xFFFF. Then input 0x0010 -> out_l=0x0010.
